// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state type, key codes and digit classifier for keypad operand entry.
// Holds no ports. It is imported by operand_entry_ctrl.
package keypad_pkg;
    typedef enum logic [1:0] {IDLE, ENTRY, DONE} entry_state_t;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hE;
    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction
endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect: turns a debounced key-held level into a single-cycle rise pulse.
// Ports: clk, rst (async, active-high) / level (key held) -> rise (one cycle per press).
module key_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);
    logic key_prev;
    always_ff @(posedge clk or posedge rst)
        if (rst) key_prev <= 1'b0;
        else key_prev <= level;
    assign rise = level & ~key_prev;
endmodule

// File: rtl/operand_entry_ctrl.sv
// operand_entry_ctrl: assembles NUM_OPERANDS BCD operands of up to DIGITS digits from key events.
// Ports: clk, rst (async, active-high), key_valid/key_code (keypad), ack (consumer took operands)
//        -> operands (op0 in LSBs), op_enable (one-hot active operand), digit_count, ready.
// Optional macro KEY_BACKSPACE_EN enables the 0xB backspace key in ENTRY.
module operand_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int NUM_OPERANDS = 2,
    parameter int DIGITS       = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             key_valid,
    input  logic [3:0]                       key_code,
    input  logic                             ack,
    output logic [NUM_OPERANDS*DIGITS*4-1:0] operands,
    output logic [NUM_OPERANDS-1:0]          op_enable,
    output logic [$clog2(DIGITS+1)-1:0]      digit_count,
    output logic                             ready
);
    localparam int W  = DIGITS * 4;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int IW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;

    entry_state_t state;
    logic [IW-1:0] op_idx;
    logic          key_edge;
    logic [W-1:0]  cur, shl;
    logic [CW-1:0] cnt_inc;
    logic          dig, clr, bksp, adv, last;
    int            op_off;

    key_edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .level(key_valid),
        .rise (key_edge)
    );

    assign op_off  = int'(op_idx) * W;
    assign cur     = operands[op_off +: W];
    // Dropping the top 4 bits of {cur, digit} is the left shift with the new LS digit.
    assign shl     = W'({cur, key_code});
    assign cnt_inc = digit_count + 1'b1;
    assign last    = op_idx == IW'(NUM_OPERANDS - 1);
    // A digit in IDLE is entry into operand 0, so it shares the ENTRY digit path.
    assign dig     = is_digit(key_code);
    assign clr     = (state == ENTRY) && (key_code == KEY_CLR);
`ifdef KEY_BACKSPACE_EN
    assign bksp    = (state == ENTRY) && (key_code == KEY_BKSP) && (digit_count != '0);
`else
    assign bksp    = 1'b0;
`endif
    assign adv     = (dig && cnt_inc == CW'(DIGITS)) ||
                     ((state == ENTRY) && (key_code == KEY_ENTER) && (digit_count != '0));
    assign op_enable = (state == ENTRY) ? NUM_OPERANDS'(1) << op_idx : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            operands    <= '0;
            op_idx      <= '0;
            digit_count <= '0;
            ready       <= 1'b0;
        end else if (state == DONE) begin
            // A key edge coinciding with ack is dropped on purpose.
            if (ack) begin
                state    <= IDLE;
                ready    <= 1'b0;
                operands <= '0;
                op_idx   <= '0;
            end
        end else if (key_edge) begin
            if (dig) operands[op_off +: W] <= shl;
            if (clr) operands[op_off +: W] <= '0;
            if (bksp) operands[op_off +: W] <= cur >> 4;
            if (adv) begin
                digit_count <= '0;
                if (last) begin
                    state <= DONE;
                    ready <= 1'b1;
                end else begin
                    op_idx <= op_idx + 1'b1;
                    state  <= ENTRY;
                end
            end else if (dig) begin
                digit_count <= cnt_inc;
                state       <= ENTRY;
            end else if (clr) begin
                digit_count <= '0;
            end else if (bksp) begin
                digit_count <= digit_count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_operand_entry_ctrl.sv
// tb_operand_entry_ctrl: directed plus random key sequences against a digit-accumulating reference model.
module tb_operand_entry_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        ack = 1'b0;
    logic [23:0] operands;
    logic [1:0]  op_enable;
    logic [1:0]  digit_count;
    logic        ready;

    int vectors = 0;
    int miscompares = 0;

    logic [11:0] m_ops [2];
    int          m_idx, m_cnt, m_phase;
    logic        m_rdy;

    operand_entry_ctrl #(.NUM_OPERANDS(2), .DIGITS(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .ack        (ack),
        .operands   (operands),
        .op_enable  (op_enable),
        .digit_count(digit_count),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ops[0] = '0;
        m_ops[1] = '0;
        m_idx = 0;
        m_cnt = 0;
        m_phase = 0;
        m_rdy = 1'b0;
    endtask

    task automatic model_advance();
        m_cnt = 0;
        if (m_idx < 1) m_idx++;
        else begin
            m_phase = 2;
            m_rdy = 1'b1;
        end
    endtask

    task automatic model_key(input int code);
        if (m_phase == 2) return;
        if (code <= 9) begin
            m_ops[m_idx] = 12'((m_ops[m_idx] * 16) + code);
            m_cnt++;
            m_phase = 1;
            if (m_cnt == 3) model_advance();
        end else if (m_phase == 1 && code == 14 && m_cnt > 0) begin
            model_advance();
        end else if (m_phase == 1 && code == 12) begin
            m_ops[m_idx] = '0;
            m_cnt = 0;
        end
    endtask

    task automatic model_ack();
        if (m_phase != 2) return;
        model_reset();
    endtask

    task automatic check_all(input string tag);
        logic [23:0] e_ops;
        logic [1:0]  e_en;
        e_ops = {m_ops[1], m_ops[0]};
        e_en  = (m_phase == 1) ? 2'(1 << m_idx) : 2'b00;
        vectors += 4;
        assert (operands === e_ops) else begin
            miscompares++;
            $error("FAIL %s operands got %h expected %h", tag, operands, e_ops);
        end
        assert (op_enable === e_en) else begin
            miscompares++;
            $error("FAIL %s op_enable got %b expected %b", tag, op_enable, e_en);
        end
        assert (digit_count === 2'(m_cnt)) else begin
            miscompares++;
            $error("FAIL %s digit_count got %0d expected %0d", tag, digit_count, m_cnt);
        end
        assert (ready === m_rdy) else begin
            miscompares++;
            $error("FAIL %s ready got %b expected %b", tag, ready, m_rdy);
        end
    endtask

    // Press at a negedge, hold for `hold` cycles, release for one cycle; checks after the
    // capturing edge and again after release so a held key counting twice is caught.
    task automatic press(input int code, input int hold, input string tag);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'(code);
        @(negedge clk);
        model_key(code);
        check_all({tag, "_edge"});
        repeat (hold - 1) @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        check_all({tag, "_rel"});
    endtask

    task automatic do_ack(input logic with_key, input string tag);
        @(negedge clk);
        ack = 1'b1;
        key_valid = with_key;
        key_code = 4'h7;
        @(negedge clk);
        ack = 1'b0;
        model_ack();
        check_all(tag);
        key_valid = 1'b0;
        @(negedge clk);
        check_all({tag, "_rel"});
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all("post_reset");

        press(1, 1, "a1"); press(2, 1, "a2"); press(3, 1, "a3");
        press(4, 1, "a4"); press(5, 1, "a5"); press(6, 2, "a6");
        press(3, 1, "done_key"); press(14, 1, "done_enter");
        do_ack(1'b1, "ack_keydrop");

        press(14, 1, "idle_enter"); press(7, 1, "b7"); press(14, 1, "b_ent");
        press(14, 1, "b_ent0"); press(9, 1, "b9"); press(14, 1, "b_ent2");
        do_ack(1'b0, "ack2");

        press(5, 10, "hold5"); press(2, 1, "c2"); press(12, 1, "clr");
        press(8, 1, "c8"); press(11, 1, "bksp_nop"); press(10, 1, "a_nop");

        // Asynchronous reset between clock edges must clear outputs before the next edge.
        press(1, 1, "r1");
        @(negedge clk);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("async_rst");
        #1 rst = 1'b0;
        @(negedge clk);
        check_all("after_rst");

        for (int i = 0; i < 60; i++) begin
            int code;
            code = ($urandom_range(0, 2) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            if (m_rdy && $urandom_range(0, 1) == 1) do_ack($urandom_range(0, 1) == 1, "rnd_ack");
            else press(code, int'($urandom_range(1, 3)), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
